// File: rtl/coin_pkg.sv
// Shared coin codes and emitter state type for the coin acceptor front end.
package coin_pkg;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;

    typedef enum logic {
        StIdle,
        StGap
    } emit_state_e;

endpackage

// File: rtl/coin_debounce.sv
// One coin-sensor channel: 2-flop synchroniser, debounce filter, rise pulse and jam detector.
module coin_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned JAM_CYCLES      = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic jam
);

    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned JW = $clog2(JAM_CYCLES + 1);
    localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [JW-1:0] JAM_MAX  = JW'(JAM_CYCLES);
    localparam logic [JW-1:0] JAM_LAST = JW'(JAM_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [DW-1:0] db_cnt;
    logic [JW-1:0] jam_cnt;
    logic          flip;

    // Combinational so the pending counter updates on the same edge the level flips.
    assign flip = (sync2 != level) && (db_cnt == DB_LAST);
    assign rise = flip && !level;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            db_cnt  <= '0;
            jam_cnt <= '0;
            jam     <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;

            if (sync2 == level) begin
                db_cnt <= '0;
            end else if (flip) begin
                db_cnt <= '0;
                level  <= ~level;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end

            if (flip && level) begin
                jam_cnt <= '0;
                jam     <= 1'b0;
            end else if (level && (jam_cnt != JAM_MAX)) begin
                jam_cnt <= jam_cnt + 1'b1;
                if (jam_cnt == JAM_LAST) begin
                    jam <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor: debounces two sensors, queues coin events and serialises them into
// single-cycle coin codes separated by idle gaps.
module coin_acceptor
    import coin_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned GAP_CYCLES      = 1,
    parameter int unsigned PEND_MAX        = 3,
    parameter int unsigned JAM_CYCLES      = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       coin5_raw,
    input  logic       coin10_raw,
    input  logic       hold,
    output logic [1:0] in_code,
    output logic       reject,
    output logic [1:0] jam
);

    localparam int unsigned PW = $clog2(PEND_MAX + 1);
    localparam int unsigned GW = $clog2(GAP_CYCLES + 1);
    localparam logic [PW-1:0] PEND_TOP = PW'(PEND_MAX);
    localparam logic [GW-1:0] GAP_INIT = GW'(GAP_CYCLES);
    localparam logic [GW-1:0] GAP_LAST = GW'(1);

    logic          level5, level10;
    logic          rise5, rise10;
    logic          jam5, jam10;
    logic [PW-1:0] pend5, pend10;
    logic [GW-1:0] gap_cnt;
    emit_state_e   state;
    logic          can_emit, drain5, drain10, ovf5, ovf10;

    coin_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .JAM_CYCLES      (JAM_CYCLES)
    ) u_deb5 (
        .clk   (clk),
        .rst   (rst),
        .raw   (coin5_raw),
        .level (level5),
        .rise  (rise5),
        .jam   (jam5)
    );

    coin_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .JAM_CYCLES      (JAM_CYCLES)
    ) u_deb10 (
        .clk   (clk),
        .rst   (rst),
        .raw   (coin10_raw),
        .level (level10),
        .rise  (rise10),
        .jam   (jam10)
    );

    // Jam bits already clear on the falling edge of the level; the mask is belt and braces.
    assign jam = {jam10 & level10, jam5 & level5};

    always_comb begin
        can_emit = (state == StIdle) && !hold;
        drain10  = can_emit && (pend10 != '0);
        drain5   = can_emit && (pend10 == '0) && (pend5 != '0);
        ovf5     = rise5 && !drain5 && (pend5 == PEND_TOP);
        ovf10    = rise10 && !drain10 && (pend10 == PEND_TOP);
    end

    function automatic logic [PW-1:0] pend_upd(input logic [PW-1:0] p,
                                               input logic ev, input logic dr);
        if (ev && !dr && (p != PEND_TOP)) begin
            return p + 1'b1;
        end else if (dr && !ev) begin
            return p - 1'b1;
        end
        return p;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= StIdle;
            gap_cnt <= '0;
            in_code <= COIN_NONE;
            reject  <= 1'b0;
            pend5   <= '0;
            pend10  <= '0;
        end else begin
            reject <= ovf5 | ovf10;
            pend5  <= pend_upd(pend5, rise5, drain5);
            pend10 <= pend_upd(pend10, rise10, drain10);
            unique case (state)
                StIdle: begin
                    if (drain10) begin
                        in_code <= COIN_10;
                        state   <= StGap;
                        gap_cnt <= GAP_INIT;
                    end else if (drain5) begin
                        in_code <= COIN_5;
                        state   <= StGap;
                        gap_cnt <= GAP_INIT;
                    end else begin
                        in_code <= COIN_NONE;
                    end
                end
                StGap: begin
                    in_code <= COIN_NONE;
                    gap_cnt <= gap_cnt - 1'b1;
                    if (gap_cnt == GAP_LAST) begin
                        state <= StIdle;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor with hand-computed cycle-exact expectations.
module tb_coin_acceptor;
    import coin_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       coin5_raw = 1'b0;
    logic       coin10_raw = 1'b0;
    logic       hold = 1'b0;
    logic [1:0] in_code;
    logic       reject;
    logic [1:0] jam;

    int total = 0;
    int bad   = 0;
    int n5    = 0;
    int n10   = 0;
    int n11   = 0;
    int nrej  = 0;

    coin_acceptor #(
        .DEBOUNCE_CYCLES (4),
        .GAP_CYCLES      (1),
        .PEND_MAX        (3),
        .JAM_CYCLES      (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .coin5_raw  (coin5_raw),
        .coin10_raw (coin10_raw),
        .hold       (hold),
        .in_code    (in_code),
        .reject     (reject),
        .jam        (jam)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n clock edges, sampling 1 ns after each and tallying outputs.
    task automatic run(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (in_code === COIN_5) n5++;
            if (in_code === COIN_10) n10++;
            if (in_code === 2'b11) n11++;
            if (reject === 1'b1) nrej++;
        end
    endtask

    task automatic clear_counts;
        n5   = 0;
        n10  = 0;
        n11  = 0;
        nrej = 0;
    endtask

    task automatic pulse5(input int hi, input int lo);
        coin5_raw = 1'b1;
        run(hi);
        coin5_raw = 1'b0;
        run(lo);
    endtask

    initial begin
        // Reset state
        run(2);
        check("rst_in_code", in_code, COIN_NONE);
        check("rst_reject", reject, 0);
        check("rst_jam", jam, 2'b00);
        rst = 1'b1;
        run(2);

        // Single coin10 plus jam on a held line
        clear_counts();
        coin10_raw = 1'b1;
        run(6);
        check("single_e5_none", in_code, COIN_NONE);
        run(1);
        check("single_e6_c10", in_code, COIN_10);
        run(1);
        check("single_e7_none", in_code, COIN_NONE);
        run(13);
        check("jam_e20_clear", jam, 2'b00);
        run(1);
        check("jam_e21_set", jam, 2'b10);
        coin10_raw = 1'b0;
        run(5);
        check("jam_held_until_fall", jam, 2'b10);
        run(1);
        check("jam_cleared_on_fall", jam, 2'b00);
        run(4);
        check("single_n10", n10, 1);
        check("single_n5", n5, 0);

        // Bounce: 3-cycle pulses never reach the debounce threshold
        clear_counts();
        for (int i = 0; i < 20; i++) begin
            coin5_raw = ((i / 3) % 2 == 0);
            run(1);
        end
        coin5_raw = 1'b1;
        run(20);
        coin5_raw = 1'b0;
        run(10);
        check("bounce_n5", n5, 1);
        check("bounce_n10", n10, 0);

        // Simultaneous coins: 10 wins, 5 follows after one gap cycle
        clear_counts();
        coin5_raw  = 1'b1;
        coin10_raw = 1'b1;
        run(6);
        check("simul_pre_none", in_code, COIN_NONE);
        run(1);
        check("simul_first_c10", in_code, COIN_10);
        run(1);
        check("simul_gap_none", in_code, COIN_NONE);
        run(1);
        check("simul_second_c5", in_code, COIN_5);
        run(1);
        check("simul_after_none", in_code, COIN_NONE);
        coin5_raw  = 1'b0;
        coin10_raw = 1'b0;
        run(10);
        check("simul_reject", nrej, 0);
        check("simul_n5", n5, 1);
        check("simul_n10", n10, 1);

        // Overflow: 4 events while held, 3 kept, one reject
        clear_counts();
        hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pulse5(6, 6);
        end
        check("ovf_reject_pulses", nrej, 1);
        check("ovf_no_codes_held", n5, 0);
        hold = 1'b0;
        run(1);
        check("ovf_code1", in_code, COIN_5);
        run(1);
        check("ovf_gap1", in_code, COIN_NONE);
        run(1);
        check("ovf_code2", in_code, COIN_5);
        run(1);
        check("ovf_gap2", in_code, COIN_NONE);
        run(1);
        check("ovf_code3", in_code, COIN_5);
        run(1);
        check("ovf_gap3", in_code, COIN_NONE);
        run(6);
        check("ovf_n5", n5, 3);
        check("ovf_reject_total", nrej, 1);

        // Reset mid-gap with 2 coins still pending
        clear_counts();
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pulse5(6, 6);
        end
        hold = 1'b0;
        run(1);
        check("rstgap_code", in_code, COIN_5);
        rst = 1'b0;
        #1;
        check("rstgap_in_code", in_code, COIN_NONE);
        check("rstgap_reject", reject, 0);
        check("rstgap_jam", jam, 2'b00);
        run(1);
        rst = 1'b1;
        run(12);
        check("rstgap_no_more_codes", n5, 1);
        check("rstgap_never_11", n11, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
